// File: rtl/pipeflop.sv
// pipeflop: valid/ready register pipeline of STAGES entries with load, flush and occupancy count.
//   clk, reset      : clock, synchronous active-high reset
//   load, val       : force val into the output stage, invalidate the rest
//   flush           : invalidate all stages, data held
//   inValid/inReady : input handshake for d
//   outValid/outReady : output handshake for q
//   count           : number of valid stages after the edge
module pipeflop #(
  parameter int WIDTH = 8,
  parameter int STAGES = 2,
  parameter type TYPE = logic [WIDTH-1:0],
  parameter TYPE RESETVAL = TYPE'('0)
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       load,
  input  TYPE                        val,
  input  logic                       flush,
  input  logic                       inValid,
  output logic                       inReady,
  input  TYPE                        d,
  output logic                       outValid,
  input  logic                       outReady,
  output TYPE                        q,
  output logic [$clog2(STAGES+1)-1:0] count
);
  localparam int CW = $clog2(STAGES+1);
  logic [STAGES-1:0] valid, rdy, nv;
  logic [STAGES:0] sv;
  logic [CW-1:0] cn;
  logic acc, normal;
  assign sv = {valid, inValid};
  assign normal = ~reset & ~load & ~flush;
  assign inReady = rdy[0] & normal;
  assign outValid = valid[STAGES-1];
  // Ready ripples back from the output: a stage advances if any stage at or after it is empty.
  always_comb begin
    acc = outReady;
    for (int i = STAGES-1; i >= 0; i--) begin
      acc = acc | ~valid[i];
      rdy[i] = acc;
    end
  end
  always_comb begin
    nv = valid;
    for (int i = 0; i < STAGES; i++) nv[i] = rdy[i] ? sv[i] : valid[i];
    nv = reset ? '0 : load ? STAGES'(1) << (STAGES-1) : flush ? '0 : nv;
    cn = '0;
    for (int i = 0; i < STAGES; i++) cn = cn + CW'(nv[i]);
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      valid <= '0;
      count <= '0;
    end else begin
      valid <= nv;
      count <= cn;
    end
  end
  for (genvar g = 0; g < STAGES; g++) begin : stg
    TYPE r, src;
    logic we;
    if (g == 0) begin : head
      assign src = d;
    end else begin : body
      assign src = stg[g-1].r;
    end
    // Data only moves when a valid item arrives; bubbles leave the old data in place.
    assign we = normal & rdy[g] & sv[g];
    always_ff @(posedge clk) begin
      if (reset) r <= RESETVAL;
      else if (load) begin
        if (g == STAGES-1) r <= val;
      end else if (we) r <= src;
    end
  end
  assign q = stg[STAGES-1].r;
endmodule

// File: tb/tb_pipeflop.sv
// tb_pipeflop: directed vector bench for pipeflop with STAGES=2, WIDTH=8.
module tb_pipeflop;
  logic clk = 0, reset, load, flush, inValid, inReady, outValid, outReady;
  logic [7:0] val, d, q;
  logic [1:0] count;
  int tests = 0, fails = 0;

  pipeflop #(.WIDTH(8), .STAGES(2)) dut (
    .clk(clk), .reset(reset), .load(load), .val(val), .flush(flush),
    .inValid(inValid), .inReady(inReady), .d(d), .outValid(outValid),
    .outReady(outReady), .q(q), .count(count)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic rst, ld;
    logic [7:0] v;
    logic fl, iv;
    logic [7:0] dd;
    logic ordy, eir;
    logic [7:0] eq;
    logic eov;
    logic [1:0] ecnt;
  } vec_t;
  vec_t vt[23];

  task automatic chk(input string nm, input int idx, input logic [7:0] act, input logic [7:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s[%0d]: got %0h, expected %0h", nm, idx, act, exp);
    end
  endtask

  initial begin
    //          rst ld val    fl iv d      or ir q      ov cnt
    vt[0]  = '{1, 1, 8'hFF, 0, 0, 8'h00, 0, 0, 8'h00, 0, 0};
    vt[1]  = '{0, 0, 8'h00, 0, 0, 8'h00, 1, 1, 8'h00, 0, 0};
    vt[2]  = '{0, 0, 8'h00, 0, 1, 8'h11, 1, 1, 8'h00, 0, 1};
    vt[3]  = '{0, 0, 8'h00, 0, 1, 8'h22, 1, 1, 8'h11, 1, 2};
    vt[4]  = '{0, 0, 8'h00, 0, 1, 8'h33, 1, 1, 8'h22, 1, 2};
    vt[5]  = '{0, 0, 8'h00, 0, 0, 8'h99, 1, 1, 8'h33, 1, 1};
    vt[6]  = '{0, 0, 8'h00, 0, 0, 8'h00, 1, 1, 8'h33, 0, 0};
    vt[7]  = '{0, 0, 8'h00, 0, 1, 8'h11, 0, 1, 8'h33, 0, 1};
    vt[8]  = '{0, 0, 8'h00, 0, 1, 8'h22, 0, 1, 8'h11, 1, 2};
    vt[9]  = '{0, 0, 8'h00, 0, 1, 8'h55, 0, 0, 8'h11, 1, 2};
    vt[10] = '{0, 0, 8'h00, 0, 1, 8'h55, 1, 1, 8'h22, 1, 2};
    vt[11] = '{0, 0, 8'h00, 0, 0, 8'h00, 1, 1, 8'h55, 1, 1};
    vt[12] = '{0, 0, 8'h00, 0, 1, 8'h44, 0, 1, 8'h55, 1, 2};
    vt[13] = '{0, 1, 8'hA5, 1, 1, 8'h66, 1, 0, 8'hA5, 1, 1};
    vt[14] = '{0, 0, 8'h00, 0, 1, 8'h77, 0, 1, 8'hA5, 1, 2};
    vt[15] = '{0, 0, 8'h00, 1, 1, 8'h88, 1, 0, 8'hA5, 0, 0};
    vt[16] = '{0, 0, 8'h00, 0, 0, 8'h00, 1, 1, 8'hA5, 0, 0};
    vt[17] = '{0, 0, 8'h00, 0, 1, 8'h12, 1, 1, 8'hA5, 0, 1};
    vt[18] = '{0, 0, 8'h00, 0, 0, 8'h00, 0, 1, 8'h12, 1, 1};
    vt[19] = '{1, 1, 8'hFF, 0, 1, 8'h34, 1, 0, 8'h00, 0, 0};
    vt[20] = '{0, 0, 8'h00, 0, 0, 8'h00, 1, 1, 8'h00, 0, 0};
    vt[21] = '{0, 1, 8'h5A, 0, 1, 8'h11, 0, 0, 8'h5A, 1, 1};
    vt[22] = '{0, 0, 8'h00, 0, 0, 8'h00, 1, 1, 8'h5A, 0, 0};
    reset = 1; load = 0; val = 0; flush = 0; inValid = 0; d = 0; outReady = 0;
    for (int i = 0; i < 23; i++) begin
      @(negedge clk);
      reset = vt[i].rst; load = vt[i].ld; val = vt[i].v; flush = vt[i].fl;
      inValid = vt[i].iv; d = vt[i].dd; outReady = vt[i].ordy;
      #1;
      if (i > 0) chk("inReady", i, 8'(inReady), 8'(vt[i].eir));
      @(posedge clk);
      #1;
      chk("q", i, q, vt[i].eq);
      chk("outValid", i, 8'(outValid), 8'(vt[i].eov));
      chk("count", i, 8'(count), 8'(vt[i].ecnt));
    end
    // Latency from accept to outValid on an empty pipeline, counting the accept edge.
    begin
      int lat;
      @(negedge clk);
      reset = 0; load = 0; flush = 0; inValid = 1; d = 8'hC3; outReady = 1;
      @(posedge clk);
      #1;
      inValid = 0;
      lat = 1;
      while (!outValid && lat < 10) begin
        @(posedge clk);
        #1;
        lat++;
      end
      chk("latency", 0, 8'(lat), 8'd2);
      chk("lat_q", 0, q, 8'hC3);
      @(posedge clk);
      #1;
      chk("lat_drain_ov", 0, 8'(outValid), 8'd0);
      chk("lat_drain_cnt", 0, 8'(count), 8'd0);
    end
    // Back-to-back stream at full rate: one item out per cycle in order.
    begin
      logic [7:0] exp[4] = '{8'h01, 8'h02, 8'h03, 8'h04};
      @(negedge clk);
      inValid = 1; outReady = 1; d = 8'h01;
      for (int k = 0; k < 6; k++) begin
        @(posedge clk);
        #1;
        if (k >= 1 && k <= 4) chk("stream_q", k, q, exp[k-1]);
        @(negedge clk);
        d = d + 8'h01;
        if (k >= 3) inValid = 0;
      end
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
